// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scheduler.
// Segment codes are active-low, bit order gfedcba, for common-anode displays.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element 0 is the rightmost entry: index the table directly with the hex value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/disp_mux_sched_if.sv
// Control/display bundle between a digit producer and the display scheduler.
// The producer holds update_req and digits stable until update_ack is seen.
interface disp_mux_sched_if #(
    parameter int NDIGITS    = 4,
    parameter int DWELL_BITS = 8
);
    logic [4*NDIGITS-1:0]  digits;
    logic [NDIGITS-1:0]    digit_en;
    logic [DWELL_BITS-1:0] dwell;
    logic                  update_req;
    logic                  update_ack;
    logic [6:0]            seg;
    logic [NDIGITS-1:0]    enables;
    logic                  frame_done;

    modport master (
        output digits, digit_en, dwell, update_req,
        input  update_ack, seg, enables, frame_done
    );

    modport slave (
        input  digits, digit_en, dwell, update_req,
        output update_ack, seg, enables, frame_done
    );
endinterface

// File: rtl/seg_decode.sv
// Combinational hex-to-segment lookup (active-low gfedcba), zero latency.
module seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/disp_mux_sched.sv
// Time-multiplexes NDIGITS hex digits onto one segment bus; optional dead time between digits under DISP_BLANK_EN.
// enables/seg are registered and valid in the state they belong to; frame_done/update_ack are same-cycle strobes.
module disp_mux_sched
    import disp_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int DWELL_BITS   = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    disp_mux_sched_if.slave bus
);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    typedef logic [IW-1:0] idx_t;

    if (NDIGITS < 2 || NDIGITS > 8 || BLANK_CYCLES < 0 || BLANK_CYCLES > 15) begin : g_bad_params
        $error("disp_mux_sched: NDIGITS or BLANK_CYCLES out of range");
    end

    disp_state_t           state, state_n;
    idx_t                  idx, idx_n, lowest, nxt;
    logic [DWELL_BITS-1:0] count, count_n, dwell_load;
    logic [4*NDIGITS-1:0]  disp_reg;
    logic                  ack_q, idle_acked, idle_acked_n;
    logic                  any_en, expire, boundary, ack;
    logic [NDIGITS-1:0]    enables_q, enables_n;
    logic [6:0]            seg_q, seg_n, seg_dec;
    logic [3:0]            nib_n;
`ifdef DISP_BLANK_EN
    logic [3:0]            bcnt, bcnt_n;
`endif

    function automatic logic bit_at(input logic [NDIGITS-1:0] v, input int n);
        logic [NDIGITS-1:0] s;
        s = v >> n;
        return s[0];
    endfunction

    // Next enabled digit strictly above cur, wrapping; returns cur when it is the only one.
    function automatic idx_t next_set(input logic [NDIGITS-1:0] en, input idx_t cur);
        idx_t r;
        logic found;
        int   j;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= NDIGITS; k++) begin
            j = int'(cur) + k;
            if (j >= NDIGITS) j = j - NDIGITS;
            if (!found && bit_at(en, j)) begin
                r     = idx_t'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin : next_state_comb
        any_en     = |bus.digit_en;
        dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
        lowest     = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            if (bit_at(bus.digit_en, i)) lowest = idx_t'(i);
        end
        nxt      = next_set(bus.digit_en, idx);
        expire   = (state == SHOW) && ((count == '0) || !bit_at(bus.digit_en, int'(idx)));
        boundary = expire && any_en && (nxt <= idx);
        ack      = !reset && bus.update_req && !ack_q &&
                   (boundary || ((state == IDLE) && !idle_acked));

        state_n = state;
        idx_n   = idx;
        count_n = count;
`ifdef DISP_BLANK_EN
        bcnt_n  = bcnt;
`endif
        if (!any_en) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = lowest;
                    count_n = dwell_load;
                end
                SHOW: begin
                    if (expire) begin
                        idx_n = nxt;
`ifdef DISP_BLANK_EN
                        if (BLANK_CYCLES > 0) begin
                            state_n = BLANK;
                            bcnt_n  = 4'(BLANK_CYCLES - 1);
                        end else begin
                            count_n = dwell_load;
                        end
`else
                        count_n = dwell_load;
`endif
                    end else begin
                        count_n = count - 1'b1;
                    end
                end
`ifdef DISP_BLANK_EN
                BLANK: begin
                    if (bcnt == 4'd0) begin
                        state_n = SHOW;
                        count_n = dwell_load;
                    end else begin
                        bcnt_n = bcnt - 4'd1;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
        idle_acked_n = (state_n == IDLE) && (idle_acked || ack);
    end

    // A capture on this edge must be visible on the very first digit shown afterwards.
    always_comb begin : output_comb
        nib_n     = ack ? 4'(bus.digits >> (4 * int'(idx_n)))
                        : 4'(disp_reg >> (4 * int'(idx_n)));
        enables_n = '0;
        seg_n     = SEG_BLANK;
        if (state_n == SHOW) begin
            enables_n = {{(NDIGITS-1){1'b0}}, 1'b1} << idx_n;
            seg_n     = seg_dec;
        end
    end

    seg_decode u_seg_decode (
        .hex (nib_n),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            count      <= '0;
            disp_reg   <= '0;
            ack_q      <= 1'b0;
            idle_acked <= 1'b0;
            enables_q  <= '0;
            seg_q      <= SEG_BLANK;
`ifdef DISP_BLANK_EN
            bcnt       <= '0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            count      <= count_n;
            ack_q      <= ack;
            idle_acked <= idle_acked_n;
            enables_q  <= enables_n;
            seg_q      <= seg_n;
            if (ack) disp_reg <= bus.digits;
`ifdef DISP_BLANK_EN
            bcnt       <= bcnt_n;
`endif
        end
    end

    assign bus.enables    = enables_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = boundary;
    assign bus.update_ack = ack;

endmodule
